sram_rr_arbiter: RTL and testbench
==================================

SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 Parameter NumReq, default 4: number of requesters, SHALL be 2..16.
REQ-002 Parameter AddrWidth, default 7: memory word address width.
REQ-003 Parameter DataWidth, default 32: data width.
REQ-004 Parameter ByteWidth, default 8: byte width; BeWidth = ceil(DataWidth/ByteWidth).
REQ-005 Parameter MemLatency, default 1: memory read latency in cycles, SHALL be 1..4.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 req_valid_i  in  NumReq  per-requester request valid.
REQ-009 req_ready_o  out  NumReq  per-requester grant/accept.
REQ-010 req_we_i  in  NumReq  write enable per requester.
REQ-011 req_addr_i  in  NumReq x AddrWidth  address per requester.
REQ-012 req_wdata_i  in  NumReq x DataWidth  write data per requester.
REQ-013 req_be_i  in  NumReq x BeWidth  byte enables per requester.
REQ-014 rsp_valid_o  out  NumReq  read response valid, one-hot or zero.
REQ-015 rsp_rdata_o  out  DataWidth  read data, shared by all requesters.
REQ-016 mem_req_o, mem_we_o  out  1 each  single memory port request/write.
REQ-017 mem_addr_o / mem_wdata_o / mem_be_o  out  AddrWidth / DataWidth / BeWidth  memory port payload.
REQ-018 mem_rdata_i  in  DataWidth  memory read data, valid MemLatency cycles after a read request.

Function
REQ-019 Handshake: a request SHALL be accepted in the cycle where req_valid_i[i] and req_ready_o[i] are both high; requesters hold valid and payload stable until accepted.
REQ-020 At most one req_ready_o bit SHALL be high per cycle; req_ready_o[i] SHALL be high only if req_valid_i[i] is high (combinational grant).
REQ-021 Arbitration SHALL be round-robin: the search starts at index ptr_q, ascending with wrap at NumReq-1 to 0; the first valid index wins.
REQ-022 After an accept by index k, ptr_q SHALL become (k+1) mod NumReq on the next edge; with no accept, ptr_q SHALL hold.
REQ-023 mem_req_o SHALL equal OR of req_valid_i; mem_we_o/addr/wdata/be SHALL be the granted requester's payload, all zero when mem_req_o is low.
REQ-024 Throughput: one accept per cycle, no bubbles between back-to-back requests.
REQ-025 Response tracking: a MemLatency-deep shift pipe of {valid, id} SHALL be loaded on every accept with valid = !we.
REQ-026 rsp_valid_o[id] SHALL pulse for exactly one cycle, exactly MemLatency cycles after the accept of a read; rsp_rdata_o = mem_rdata_i in that cycle.
REQ-027 Writes SHALL produce no response; they complete on acceptance.
REQ-028 Responses cannot be back-pressured; their order SHALL equal acceptance order.
REQ-029 With no response pending, rsp_valid_o SHALL be 0 and rsp_rdata_o SHALL pass mem_rdata_i through unqualified.
REQ-030 A requester deasserting valid without acceptance is illegal; the block need not detect it.

Reset
REQ-031 On rst_ni low, asynchronously: ptr_q = 0, all response pipe valid bits = 0; hence rsp_valid_o = 0 immediately.
REQ-032 Reset mid-operation SHALL drop all in-flight read responses; none SHALL appear after release.
REQ-033 The first cycle after release SHALL arbitrate with priority starting at index 0.

Structure
REQ-034 Package sram_arb_pkg SHALL hold constant MaxNumReq = 16 and the helper function computing id width = $clog2(NumReq).
REQ-035 Sub-module sram_arb_rr SHALL implement the combinational rotate-priority grant (inputs valid vector, ptr; outputs one-hot grant, winner index).
REQ-036 ptr_q and the response pipe SHALL be the only state; no storage of payloads.

Verification
REQ-037 All 4 valid continuously, reads, ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; rsp_valid_o = 0001,0010,0100,1000 delayed by MemLatency.
REQ-038 Only req 2 valid, read addr 0x05, memory returns 0xDEADBEEF -> ready[2] same cycle, rsp_valid_o=0100 with 0xDEADBEEF exactly MemLatency cycles later.
REQ-039 Req 1 write addr 0x10 be=0011 wdata 0x12345678 -> mem_we_o=1, mem_be_o=0011, no rsp_valid_o ever; subsequent read of 0x10 by req 3 returns lower half 0x5678.
REQ-040 After grant to 3, reqs 0 and 3 valid -> req 0 granted (wrap-around), then req 3.
REQ-041 MemLatency=3, reads accepted at cycles 0,1,2 from reqs 0,1,2; rst_ni low at cycle 2 -> no rsp_valid_o in cycles 3-5, ptr_q=0 after release.
REQ-042 Idle (no valid) for 10 cycles -> mem_req_o=0, all mem payload outputs zero, ptr_q unchanged.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared constants and helpers for the round-robin SRAM port arbiter.
package sram_arb_pkg;

    // Largest requester count the arbiter is built for.
    localparam int unsigned MaxNumReq = 32'd16;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int unsigned id_width(input int unsigned num_req);
        if (num_req > 32'd1) begin
            return unsigned'($clog2(num_req));
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Combinational rotate-priority grant: search starts at i_ptr, ascends and
// wraps, and the first valid requester wins.
module sram_arb_rr
    import sram_arb_pkg::*;
#(
    parameter int unsigned NumReq = 32'd4,
    parameter int unsigned IdW    = id_width(NumReq)
) (
    input  logic [NumReq-1:0] i_valid,
    input  logic [IdW-1:0]    i_ptr,
    output logic [NumReq-1:0] o_gnt,
    output logic [IdW-1:0]    o_idx
);

    int unsigned    w_sum;
    logic [IdW-1:0] w_pos;
    logic           w_found;

    // Walk the requesters in priority order from i_ptr and latch the first hit.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = 32'd0;
        w_pos   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            w_sum = 32'(i_ptr) + i;
            w_sum = (w_sum >= NumReq) ? (w_sum - NumReq) : w_sum;
            w_pos = IdW'(w_sum);
            if (!w_found && i_valid[w_pos]) begin
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
                w_found      = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter multiplexing NumReq requesters onto one SRAM port.
// Grants are combinational; only the priority pointer and a read-response
// tracking pipe are stored, payloads pass straight through.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NumReq     = 32'd4,
    parameter int unsigned AddrWidth  = 32'd7,
    parameter int unsigned DataWidth  = 32'd32,
    parameter int unsigned ByteWidth  = 32'd8,
    parameter int unsigned MemLatency = 32'd1,
    parameter int unsigned BeWidth    = (DataWidth + ByteWidth - 32'd1) / ByteWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    input  logic [NumReq-1:0]                   req_we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
    input  logic [NumReq-1:0][BeWidth-1:0]      req_be_i,
    output logic [NumReq-1:0]                   rsp_valid_o,
    output logic [DataWidth-1:0]                rsp_rdata_o,
    output logic                                mem_req_o,
    output logic                                mem_we_o,
    output logic [AddrWidth-1:0]                mem_addr_o,
    output logic [DataWidth-1:0]                mem_wdata_o,
    output logic [BeWidth-1:0]                  mem_be_o,
    input  logic [DataWidth-1:0]                mem_rdata_i
);

    localparam int unsigned IdW = id_width(NumReq);

    logic [IdW-1:0]                   r_ptr_q;
    logic [MemLatency-1:0]            r_pipe_vld;
    logic [MemLatency-1:0][IdW-1:0]   r_pipe_id;

    logic [NumReq-1:0] w_gnt;
    logic [IdW-1:0]    w_idx;
    logic [IdW-1:0]    w_ptr_nxt;
    logic              w_any;

    sram_arb_rr #(
        .NumReq (NumReq),
        .IdW    (IdW)
    ) u_rr (
        .i_valid (req_valid_i),
        .i_ptr   (r_ptr_q),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx)
    );

    // Any valid requester is granted in the same cycle, so an accept happens
    // whenever at least one request is pending.
    assign w_any       = |req_valid_i;
    assign req_ready_o = w_gnt;
    assign w_ptr_nxt   = (w_idx == IdW'(NumReq - 32'd1)) ? '0 : (w_idx + IdW'(1));

    // Drive the memory port with the winner's payload, zeroed while idle.
    always_comb begin
        mem_req_o   = w_any;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (w_any) begin
            mem_we_o    = req_we_i[w_idx];
            mem_addr_o  = req_addr_i[w_idx];
            mem_wdata_o = req_wdata_i[w_idx];
            mem_be_o    = req_be_i[w_idx];
        end else begin
            mem_we_o    = 1'b0;
            mem_addr_o  = '0;
            mem_wdata_o = '0;
            mem_be_o    = '0;
        end
    end

    // Priority pointer moves just past the accepted requester, holds when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr_q <= '0;
        end else if (w_any) begin
            r_ptr_q <= w_ptr_nxt;
        end else begin
            r_ptr_q <= r_ptr_q;
        end
    end

    // Response pipe: one stage per memory latency cycle; reads mark a slot valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pipe_vld <= '0;
            r_pipe_id  <= '0;
        end else begin
            r_pipe_vld[0] <= w_any & ~mem_we_o;
            r_pipe_id[0]  <= w_idx;
            for (int unsigned s = 1; s < MemLatency; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                r_pipe_id[s]  <= r_pipe_id[s-1];
            end
        end
    end

    // Decode the oldest pipe slot into a one-hot response strobe.
    always_comb begin
        rsp_valid_o = '0;
        if (r_pipe_vld[MemLatency-1]) begin
            rsp_valid_o[r_pipe_id[MemLatency-1]] = 1'b1;
        end else begin
            rsp_valid_o = '0;
        end
    end

    // Read data is shared and not qualified; requesters use rsp_valid_o.
    assign rsp_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter: one instance at MemLatency=1 with a
// byte-enabled memory model, one at MemLatency=3 for latency/reset checks.
module tb_sram_rr_arbiter;

    logic clk;
    logic rst_n;

    // MemLatency = 1 instance
    logic [3:0]        valid1, ready1, we1, rsp1;
    logic [3:0][6:0]   addr1;
    logic [3:0][31:0]  wdata1;
    logic [3:0][3:0]   be1;
    logic [31:0]       rdata1, m1_wdata, m1_rdata, rd1;
    logic              m1_req, m1_we;
    logic [6:0]        m1_addr;
    logic [3:0]        m1_be;
    logic [31:0]       mem [128];

    // MemLatency = 3 instance
    logic [3:0]        valid3, ready3, we3, rsp3;
    logic [3:0][6:0]   addr3;
    logic [3:0][31:0]  wdata3;
    logic [3:0][3:0]   be3;
    logic [31:0]       rdata3, m3_wdata, m3_rdata, rd3_0, rd3_1, rd3_2;
    logic              m3_req, m3_we;
    logic [6:0]        m3_addr;
    logic [3:0]        m3_be;

    int n_vec;
    int n_err;

    sram_rr_arbiter #(.NumReq(4), .AddrWidth(7), .DataWidth(32), .ByteWidth(8), .MemLatency(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(valid1), .req_ready_o(ready1), .req_we_i(we1),
        .req_addr_i(addr1), .req_wdata_i(wdata1), .req_be_i(be1),
        .rsp_valid_o(rsp1), .rsp_rdata_o(rdata1),
        .mem_req_o(m1_req), .mem_we_o(m1_we), .mem_addr_o(m1_addr),
        .mem_wdata_o(m1_wdata), .mem_be_o(m1_be), .mem_rdata_i(m1_rdata)
    );

    sram_rr_arbiter #(.NumReq(4), .AddrWidth(7), .DataWidth(32), .ByteWidth(8), .MemLatency(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(valid3), .req_ready_o(ready3), .req_we_i(we3),
        .req_addr_i(addr3), .req_wdata_i(wdata3), .req_be_i(be3),
        .rsp_valid_o(rsp3), .rsp_rdata_o(rdata3),
        .mem_req_o(m3_req), .mem_we_o(m3_we), .mem_addr_o(m3_addr),
        .mem_wdata_o(m3_wdata), .mem_be_o(m3_be), .mem_rdata_i(m3_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle memory with byte enables, preloaded while reset is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) begin
                mem[i] <= (i < 4) ? (32'h1000_0000 + 32'(i)) : ((i == 5) ? 32'hDEAD_BEEF : 32'h0);
            end
            rd1 <= 32'h0;
        end else if (m1_req) begin
            if (m1_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (m1_be[b]) mem[m1_addr][8*b +: 8] <= m1_wdata[8*b +: 8];
                end
            end else begin
                rd1 <= mem[m1_addr];
            end
        end
    end
    assign m1_rdata = rd1;

    // Three-cycle memory returning a tag derived from the address.
    always @(posedge clk) begin
        rd3_0 <= 32'hC0DE_0000 | {25'h0, m3_addr};
        rd3_1 <= rd3_0;
        rd3_2 <= rd3_1;
    end
    assign m3_rdata = rd3_2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e;
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        valid1 = '0; we1 = '0; addr1 = '0; wdata1 = '0; be1 = '0;
        valid3 = '0; we3 = '0; addr3 = '0; wdata3 = '0; be3 = '0;
        #1;
        chk("rst_rsp1", rsp1, 4'b0000);
        chk("rst_rsp3", rsp3, 4'b0000);
        chk("rst_ptr1", dut1.r_ptr_q, 2'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // All four reading continuously: grants rotate 0,1,2,3,0.
        valid1 = 4'b1111;
        for (int i = 0; i < 4; i++) addr1[i] = 7'(i);
        for (int c = 0; c < 5; c++) begin
            #1;
            e = 4'b0001 << (c % 4);
            chk("rot_ready", ready1, e);
            if (c == 0) begin
                chk("rot_rsp", rsp1, 4'b0000);
            end else begin
                e = 4'b0001 << ((c - 1) % 4);
                chk("rot_rsp", rsp1, e);
                chk("rot_rdata", rdata1, 32'h1000_0000 + 32'((c - 1) % 4));
            end
            step();
        end
        valid1 = 4'b0000;
        #1;
        chk("rot_rsp_last", rsp1, 4'b0001);
        chk("rot_rdata_last", rdata1, 32'h1000_0000);
        chk("rot_memreq_idle", m1_req, 1'b0);
        chk("rot_ptr", dut1.r_ptr_q, 2'd1);
        step();

        // Wrap-around: grant 3, then 0 and 3 compete, 0 wins, then 3.
        valid1 = 4'b1000;
        #1; chk("wrap_g3", ready1, 4'b1000);
        step();
        valid1 = 4'b1001;
        #1; chk("wrap_g0", ready1, 4'b0001);
        chk("wrap_ptr", dut1.r_ptr_q, 2'd0);
        chk("wrap_rsp3", rsp1, 4'b1000);
        chk("wrap_rdata3", rdata1, 32'h1000_0003);
        step();
        valid1 = 4'b1000;
        #1; chk("wrap_g3b", ready1, 4'b1000);
        chk("wrap_rsp0", rsp1, 4'b0001);
        step();
        valid1 = 4'b0000;
        #1; chk("wrap_rsp3b", rsp1, 4'b1000);
        step();

        // Single requester 2 reads 0x05.
        valid1 = 4'b0100; addr1[2] = 7'h05;
        #1; chk("single_ready", ready1, 4'b0100);
        chk("single_addr", m1_addr, 7'h05);
        chk("single_we", m1_we, 1'b0);
        step();
        valid1 = 4'b0000;
        #1; chk("single_rsp", rsp1, 4'b0100);
        chk("single_rdata", rdata1, 32'hDEAD_BEEF);
        chk("single_ptr", dut1.r_ptr_q, 2'd3);
        step();
        #1; chk("single_rsp_once", rsp1, 4'b0000);

        // Partial write by req 1, then read-back by req 3.
        valid1 = 4'b0010; we1 = 4'b0010; addr1[1] = 7'h10;
        wdata1[1] = 32'h1234_5678; be1[1] = 4'b0011;
        #1; chk("wr_ready", ready1, 4'b0010);
        chk("wr_we", m1_we, 1'b1);
        chk("wr_be", m1_be, 4'b0011);
        chk("wr_addr", m1_addr, 7'h10);
        chk("wr_wdata", m1_wdata, 32'h1234_5678);
        step();
        valid1 = 4'b0000; we1 = 4'b0000;
        #1; chk("wr_norsp", rsp1, 4'b0000);
        chk("wr_ptr", dut1.r_ptr_q, 2'd2);
        step();
        valid1 = 4'b1000; addr1[3] = 7'h10;
        #1; chk("rb_ready", ready1, 4'b1000);
        chk("rb_norsp", rsp1, 4'b0000);
        step();
        valid1 = 4'b0000;
        #1; chk("rb_rsp", rsp1, 4'b1000);
        chk("rb_rdata", rdata1, 32'h0000_5678);
        step();

        // Idle with junk payloads: port outputs zero, pointer holds.
        for (int i = 0; i < 4; i++) begin
            addr1[i] = 7'h7F; wdata1[i] = 32'hFFFF_FFFF; be1[i] = 4'hF;
        end
        we1 = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("idle_req", m1_req, 1'b0);
            chk("idle_pay", {m1_we, m1_addr, m1_be, m1_wdata}, 44'h0);
            chk("idle_ready", ready1, 4'b0000);
            chk("idle_ptr", dut1.r_ptr_q, 2'd0);
            step();
        end

        // Rotating priority with partial request sets (zero-enable writes).
        be1 = '0;
        valid1 = 4'b0110; #1; chk("rr_a", ready1, 4'b0010); step();
        valid1 = 4'b0111; #1; chk("rr_b", ready1, 4'b0100); step();
        valid1 = 4'b0011; #1; chk("rr_c", ready1, 4'b0001); step();
        valid1 = 4'b0101; #1; chk("rr_d", ready1, 4'b0100); chk("rr_norsp", rsp1, 4'b0000); step();
        valid1 = 4'b0000; we1 = 4'b0000;
        #1; chk("rr_ptr", dut1.r_ptr_q, 2'd3);
        step();

        // Three-cycle latency: read by req 1 answers exactly three cycles later.
        valid3 = 4'b0010; addr3[1] = 7'h22;
        #1; chk("l3_ready", ready3, 4'b0010);
        step();
        valid3 = 4'b0000;
        #1; chk("l3_rsp_c1", rsp3, 4'b0000); step();
        #1; chk("l3_rsp_c2", rsp3, 4'b0000); step();
        #1; chk("l3_rsp_c3", rsp3, 4'b0010);
        chk("l3_rdata", rdata3, 32'hC0DE_0022); step();
        #1; chk("l3_rsp_c4", rsp3, 4'b0000); step();

        // Reset while reads 0,1,2 are in flight: nothing emerges afterwards.
        valid3 = 4'b0001; #1; chk("rr3_c0", ready3, 4'b0001); step();
        valid3 = 4'b0010; #1; chk("rr3_c1", ready3, 4'b0010); step();
        valid3 = 4'b0100;
        rst_n = 1'b0;
        #1; chk("rst3_pipe_clr", dut3.r_pipe_vld, 3'b000);
        chk("rst3_rsp", rsp3, 4'b0000);
        step();
        valid3 = 4'b0000;
        #1; chk("rst3_rsp_c3", rsp3, 4'b0000);
        rst_n = 1'b1;
        step();
        valid3 = 4'b1010; we3 = 4'b1010;
        #1; chk("rst3_ptr0", dut3.r_ptr_q, 2'd0);
        chk("rst3_prio0", ready3, 4'b0010);
        chk("rst3_rsp_c4", rsp3, 4'b0000);
        step();
        valid3 = 4'b0000; we3 = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            #1; chk("rst3_rsp_after", rsp3, 4'b0000);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
